// File: rtl/flappy_pkg.sv
// -----------------------------------------------------------------------------
// flappy_pkg
// Shared types and constants for the Flappy Birds game sequencer.
//   game_state_t : 2-bit game state (IDLE=00, PLAY=01, PAUSED=10, OVER=11)
//   LFSR_SEED    : reset/seed value of the 4-bit gap-row LFSR
//   DEFAULT_ROWS / DEFAULT_GAP : default playfield geometry
//   lfsr_step()  : one step of the x^4+x^3+1 Fibonacci LFSR
//   cnt_width()  : counter width for a modulus, never below 1 bit
// -----------------------------------------------------------------------------
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PLAY   = 2'b01,
        PAUSED = 2'b10,
        OVER   = 2'b11
    } game_state_t;

    localparam logic [3:0] LFSR_SEED    = 4'b1001;
    localparam int unsigned DEFAULT_ROWS = 16;
    localparam int unsigned DEFAULT_GAP  = 4;

    // Shift left, feed back bit3 ^ bit2; the all-zero state is unreachable
    // from any non-zero seed.
    function automatic logic [3:0] lfsr_step(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

    function automatic int unsigned cnt_width(input int unsigned m);
        return (m > 32'd1) ? $clog2(m) : 32'd1;
    endfunction

endpackage

// File: rtl/game_tick_scheduler_if.sv
// -----------------------------------------------------------------------------
// game_tick_scheduler_if
// Control/enable bundle between the game controller and the tick scheduler.
//   start, flap, collision : controller -> scheduler requests
//   state, pause           : game state and global pause
//   scroll_en, spawn_en    : barrier timing pulses, gap_top with spawn
//   fall_en, flap_en       : bird movement pulses
// Modports: master = controller side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface game_tick_scheduler_if #(
    parameter int unsigned ROWS = 16
);
    logic                    start;
    logic                    flap;
    logic                    collision;
    logic [1:0]              state;
    logic                    pause;
    logic                    scroll_en;
    logic                    spawn_en;
    logic [$clog2(ROWS)-1:0] gap_top;
    logic                    fall_en;
    logic                    flap_en;

    modport master (
        output start, flap, collision,
        input  state, pause, scroll_en, spawn_en, gap_top, fall_en, flap_en
    );

    modport slave (
        input  start, flap, collision,
        output state, pause, scroll_en, spawn_en, gap_top, fall_en, flap_en
    );
endinterface

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Modulo-MOD event counter. Counts adv pulses 0..MOD-1; wrap is high
// combinationally on the adv that takes the count from MOD-1 back to 0.
//   clk, reset : clock, synchronous active-high reset
//   clear      : synchronous restart of the count at 0
//   adv        : advance by one
//   wrap       : adv coincident with the last count
// -----------------------------------------------------------------------------
module tick_divider
    import flappy_pkg::*;
#(
    parameter int unsigned MOD = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic adv,
    output logic wrap
);
    localparam int unsigned W = cnt_width(MOD);
    localparam logic [W-1:0] LAST = W'(MOD - 32'd1);

    logic [W-1:0] cnt_r;

    assign wrap = adv && (cnt_r == LAST);

    // Modulo counter; a modulus of 1 keeps the count at 0 and wraps on every adv.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (adv) begin
            if (wrap) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/game_tick_scheduler.sv
// -----------------------------------------------------------------------------
// game_tick_scheduler
// Game state machine plus every slow timing enable of the Flappy Birds
// datapath, all derived from one BASE_DIV prescaler.
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : start/flap/collision in; state, pause, scroll_en,
//                spawn_en, gap_top, fall_en, flap_en out (all registered)
// Optional build macro: SPEEDUP_EN -- after 8 spawns in a game the scroll
// modulus halves (minimum 1) until the next IDLE->PLAY.
// -----------------------------------------------------------------------------
module game_tick_scheduler
    import flappy_pkg::*;
#(
    parameter int unsigned BASE_DIV   = 8192,
    parameter int unsigned SCROLL_DIV = 4,
    parameter int unsigned SPAWN_DIV  = 4,
    parameter int unsigned FALL_DIV   = 2,
    parameter int unsigned ROWS       = DEFAULT_ROWS,
    parameter int unsigned GAP        = DEFAULT_GAP
) (
    input  logic                 clk,
    input  logic                 reset,
    game_tick_scheduler_if.slave bus
);
    localparam int unsigned PRE_W = cnt_width(BASE_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_DIV - 32'd1);
    localparam int unsigned ROW_W = $clog2(ROWS);

    game_state_t      state_r;
    game_state_t      state_next_s;
    logic [PRE_W-1:0] presc_r;
    logic [3:0]       lfsr_r;
    logic             flap_pending_r;
    logic             pause_r;
    logic             scroll_en_r;
    logic             spawn_en_r;
    logic             fall_en_r;
    logic             flap_en_r;
    logic [ROW_W-1:0] gap_top_r;
    logic [ROW_W-1:0] gap_next_s;
    logic [31:0]      lfsr_ext_s;

    logic clear_s;
    logic run_s;
    logic base_tick_s;
    logic scroll_wrap_s;
    logic scroll_slow_wrap_s;
    logic spawn_wrap_s;
    logic fall_wrap_s;

    // Next game state; collision outranks start while playing.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_next_s = PLAY;
                else           state_next_s = IDLE;
            end
            PLAY: begin
                if (bus.collision)  state_next_s = OVER;
                else if (bus.start) state_next_s = PAUSED;
                else                state_next_s = PLAY;
            end
            PAUSED: begin
                if (bus.start) state_next_s = PLAY;
                else           state_next_s = PAUSED;
            end
            OVER: begin
                if (bus.start) state_next_s = IDLE;
                else           state_next_s = OVER;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Counters only move on cycles that stay in PLAY, so the cycle that
    // leaves PLAY can neither emit a pulse into a frozen state nor lose one.
    assign clear_s     = (state_r == IDLE) && bus.start;
    assign run_s       = (state_r == PLAY) && (state_next_s == PLAY);
    assign base_tick_s = run_s && (presc_r == PRE_LAST);

    tick_divider #(.MOD(SCROLL_DIV)) u_scroll (
        .clk(clk), .reset(reset), .clear(clear_s),
        .adv(base_tick_s), .wrap(scroll_slow_wrap_s)
    );

`ifdef SPEEDUP_EN
    localparam int unsigned FAST_DIV = (SCROLL_DIV / 32'd2 > 32'd0) ? SCROLL_DIV / 32'd2 : 32'd1;

    logic       scroll_fast_wrap_s;
    logic [3:0] spawn_cnt_r;

    tick_divider #(.MOD(FAST_DIV)) u_scroll_fast (
        .clk(clk), .reset(reset), .clear(clear_s),
        .adv(base_tick_s), .wrap(scroll_fast_wrap_s)
    );

    assign scroll_wrap_s = (spawn_cnt_r >= 4'd8) ? scroll_fast_wrap_s : scroll_slow_wrap_s;

    // Saturating count of spawns in the current game.
    always_ff @(posedge clk) begin
        if (reset) begin
            spawn_cnt_r <= 4'd0;
        end else if (clear_s) begin
            spawn_cnt_r <= 4'd0;
        end else if (spawn_wrap_s && (spawn_cnt_r != 4'd15)) begin
            spawn_cnt_r <= spawn_cnt_r + 4'd1;
        end else begin
            spawn_cnt_r <= spawn_cnt_r;
        end
    end
`else
    assign scroll_wrap_s = scroll_slow_wrap_s;
`endif

    tick_divider #(.MOD(SPAWN_DIV)) u_spawn (
        .clk(clk), .reset(reset), .clear(clear_s),
        .adv(scroll_wrap_s), .wrap(spawn_wrap_s)
    );

    tick_divider #(.MOD(FALL_DIV)) u_fall (
        .clk(clk), .reset(reset), .clear(clear_s),
        .adv(base_tick_s), .wrap(fall_wrap_s)
    );

    // Gap row from the current LFSR value, folded into 1..ROWS-GAP.
    assign lfsr_ext_s = {28'd0, lfsr_r};
    always_comb begin
        if (lfsr_ext_s > (ROWS - GAP)) begin
            gap_next_s = ROW_W'(lfsr_ext_s - GAP);
        end else begin
            gap_next_s = ROW_W'(lfsr_ext_s);
        end
    end

    // Game FSM, prescaler, LFSR, flap arbitration and registered enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            pause_r        <= 1'b1;
            presc_r        <= '0;
            lfsr_r         <= LFSR_SEED;
            flap_pending_r <= 1'b0;
            scroll_en_r    <= 1'b0;
            spawn_en_r     <= 1'b0;
            fall_en_r      <= 1'b0;
            flap_en_r      <= 1'b0;
            gap_top_r      <= '0;
        end else begin
            state_r     <= state_next_s;
            pause_r     <= (state_next_s != PLAY);
            lfsr_r      <= lfsr_step(lfsr_r);
            scroll_en_r <= scroll_wrap_s;
            spawn_en_r  <= spawn_wrap_s;
            // A pending flap takes the base tick and swallows any fall.
            flap_en_r   <= base_tick_s && flap_pending_r;
            fall_en_r   <= fall_wrap_s && !flap_pending_r;

            if (spawn_wrap_s) begin
                gap_top_r <= gap_next_s;
            end else begin
                gap_top_r <= gap_top_r;
            end

            if (clear_s || base_tick_s) begin
                presc_r <= '0;
            end else if (run_s) begin
                presc_r <= presc_r + PRE_W'(1);
            end else begin
                presc_r <= presc_r;
            end

            // A flap on the consuming tick re-arms for the following tick.
            if (!run_s) begin
                flap_pending_r <= 1'b0;
            end else if (base_tick_s && flap_pending_r) begin
                flap_pending_r <= bus.flap;
            end else begin
                flap_pending_r <= flap_pending_r | bus.flap;
            end
        end
    end

    assign bus.state     = state_r;
    assign bus.pause     = pause_r;
    assign bus.scroll_en = scroll_en_r;
    assign bus.spawn_en  = spawn_en_r;
    assign bus.gap_top   = gap_top_r;
    assign bus.fall_en   = fall_en_r;
    assign bus.flap_en   = flap_en_r;
endmodule

// File: tb/tb_game_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_game_tick_scheduler
// Self-checking bench: FSM vector table, hand-written timing sequences and
// randomized traffic, all compared each cycle against a reference model that
// derives pulses from the count of PLAY cycles.
// -----------------------------------------------------------------------------
module tb_game_tick_scheduler;
    localparam int BASE = 4;
    localparam int SCR  = 2;
    localparam int SPN  = 3;
    localparam int FALL = 1;
    localparam int ROWS = 16;
    localparam int GAP  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    game_tick_scheduler_if #(.ROWS(ROWS)) bus ();

    game_tick_scheduler #(
        .BASE_DIV(BASE), .SCROLL_DIV(SCR), .SPAWN_DIV(SPN),
        .FALL_DIV(FALL), .ROWS(ROWS), .GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_state = 0;
    int m_play  = 0;
    int m_pend  = 0;
    int m_lfsr  = 9;
    logic [1:0] e_state = 2'd0;
    logic e_pause = 1'b1, e_scroll = 1'b0, e_spawn = 1'b0, e_fall = 1'b0, e_flap = 1'b0;
    logic [3:0] e_gap = 4'd0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lfsr_next(input int l);
        return ((l * 2) % 16) + (((l / 8) ^ (l / 4)) & 1);
    endfunction

    // Pulses follow from how many cycles the game has spent running:
    // every BASE-th running cycle is base tick number n.
    task automatic model_step(input bit s, input bit f, input bit c, input bit r);
        int ns;
        int n;
        bit run;
        e_scroll = 1'b0; e_spawn = 1'b0; e_fall = 1'b0; e_flap = 1'b0;
        if (r) begin
            m_state = 0; m_play = 0; m_pend = 0; m_lfsr = 9;
            e_gap = 4'd0; e_state = 2'd0; e_pause = 1'b1;
        end else begin
            run = (m_state == 1) && !s && !c;
            if (run) begin
                m_play++;
                if (m_play % BASE == 0) begin
                    n = m_play / BASE;
                    e_scroll = (n % SCR == 0);
                    e_spawn  = (n % (SCR * SPN) == 0);
                    if (m_pend != 0) begin
                        e_flap = 1'b1;
                        m_pend = 0;
                    end else begin
                        e_fall = (n % FALL == 0);
                    end
                    if (e_spawn)
                        e_gap = 4'((m_lfsr > ROWS - GAP) ? m_lfsr - GAP : m_lfsr);
                end
                if (f) m_pend = 1;
            end else begin
                m_pend = 0;
            end
            ns = m_state;
            case (m_state)
                0: if (s) ns = 1;
                1: if (c) ns = 3; else if (s) ns = 2;
                2: if (s) ns = 1;
                default: if (s) ns = 0;
            endcase
            if (m_state == 0 && s) m_play = 0;
            m_state = ns;
            e_state = 2'(m_state);
            e_pause = (m_state != 1);
            m_lfsr  = lfsr_next(m_lfsr);
        end
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic cyc(input bit s, input bit f, input bit c, input bit r = 1'b0);
        logic [10:0] act;
        logic [10:0] exp;
        bus.start = s; bus.flap = f; bus.collision = c; reset = r;
        model_step(s, f, c, r);
        @(posedge clk);
        #1;
        act = {bus.state, bus.pause, bus.scroll_en, bus.spawn_en, bus.fall_en, bus.flap_en, bus.gap_top};
        exp = {e_state, e_pause, e_scroll, e_spawn, e_fall, e_flap, e_gap};
        check("model{state,pause,scroll,spawn,fall,flap,gap}", int'(act), int'(exp));
        check("flap_fall_exclusive", int'(bus.flap_en & bus.fall_en), 0);
    endtask

    typedef struct {
        bit s;
        bit f;
        bit c;
        logic [1:0] exp_state;
        bit exp_pause;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int first_scroll, first_fall, first_spawn;
        int n_scroll, n_fall, n_spawn, n_flap, coincide, bad_fall, hold_pulses;
        int gaps[2];
        int range_bad, stable_bad;
        logic [3:0] last_gap;

        bus.start = 1'b0; bus.flap = 1'b0; bus.collision = 1'b0;

        tbl[0]  = '{1, 0, 0, 2'd1, 0};
        tbl[1]  = '{0, 1, 0, 2'd1, 0};
        tbl[2]  = '{0, 0, 1, 2'd3, 1};
        tbl[3]  = '{0, 1, 0, 2'd3, 1};
        tbl[4]  = '{1, 0, 0, 2'd0, 1};
        tbl[5]  = '{0, 0, 1, 2'd0, 1};
        tbl[6]  = '{1, 0, 0, 2'd1, 0};
        tbl[7]  = '{1, 0, 0, 2'd2, 1};
        tbl[8]  = '{0, 0, 1, 2'd2, 1};
        tbl[9]  = '{1, 0, 0, 2'd1, 0};
        tbl[10] = '{1, 0, 1, 2'd3, 1};
        tbl[11] = '{1, 0, 0, 2'd0, 1};

        // Reset values
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("reset_state", int'(bus.state), 0);
        check("reset_pause", int'(bus.pause), 1);
        check("reset_gap", int'(bus.gap_top), 0);

        // FSM transition table
        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].f, tbl[i].c);
            check($sformatf("fsm_state[%0d]", i), int'(bus.state), int'(tbl[i].exp_state));
            check($sformatf("fsm_pause[%0d]", i), int'(bus.pause), int'(tbl[i].exp_pause));
        end

        // 1: pulse cadence from a fresh start right after reset
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0);
        check("t1_state", int'(bus.state), 1);
        check("t1_pause", int'(bus.pause), 0);
        first_scroll = -1; first_spawn = -1;
        n_scroll = 0; n_fall = 0; n_spawn = 0; coincide = 0; bad_fall = 0;
        for (int k = 1; k <= 48; k++) begin
            cyc(0, 0, 0);
            if (bus.scroll_en) begin
                n_scroll++;
                if (first_scroll < 0) first_scroll = k;
            end
            if (bus.fall_en) begin
                n_fall++;
                if (k % 4 != 0) bad_fall++;
            end
            if (bus.spawn_en) begin
                if (first_spawn < 0) first_spawn = k;
                if (bus.scroll_en) coincide++;
                if (n_spawn < 2) gaps[n_spawn] = int'(bus.gap_top);
                n_spawn++;
            end
        end
        check("t1_first_scroll", first_scroll, 8);
        check("t1_scroll_count", n_scroll, 6);
        check("t1_fall_count", n_fall, 12);
        check("t1_fall_phase", bad_fall, 0);
        check("t1_first_spawn", first_spawn, 24);
        check("t1_spawn_count", n_spawn, 2);
        check("t1_spawn_with_scroll", coincide, 2);
        check("t1_gap0", gaps[0], 10);
        check("t1_gap1", gaps[1], 9);

        // 2: pause at cycle 10 for 20 cycles, then resume
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0);
        n_scroll = 0; n_fall = 0; hold_pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0);
            n_scroll += int'(bus.scroll_en);
            n_fall   += int'(bus.fall_en);
        end
        cyc(1, 0, 0);
        check("t2_paused", int'(bus.state), 2);
        hold_pulses += int'(bus.scroll_en) + int'(bus.fall_en) + int'(bus.spawn_en) + int'(bus.flap_en);
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1, 0);
            hold_pulses += int'(bus.scroll_en) + int'(bus.fall_en) + int'(bus.spawn_en) + int'(bus.flap_en);
        end
        check("t2_hold_pulses", hold_pulses, 0);
        check("t2_hold_state", int'(bus.state), 2);
        cyc(1, 0, 0);
        check("t2_resumed", int'(bus.state), 1);
        first_scroll = -1; first_fall = -1;
        for (int r = 1; r <= 38; r++) begin
            cyc(0, 0, 0);
            n_scroll += int'(bus.scroll_en);
            n_fall   += int'(bus.fall_en);
            if (bus.scroll_en && first_scroll < 0) first_scroll = r;
            if (bus.fall_en && first_fall < 0) first_fall = r;
        end
        check("t2_resume_first_fall", first_fall, 2);
        check("t2_resume_first_scroll", first_scroll, 6);
        check("t2_total_scroll", n_scroll, 6);
        check("t2_total_fall", n_fall, 12);

        // 3: three flaps in one base period
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0);
        n_flap = 0;
        cyc(0, 1, 0); n_flap += int'(bus.flap_en);
        cyc(0, 1, 0); n_flap += int'(bus.flap_en);
        cyc(0, 1, 0); n_flap += int'(bus.flap_en);
        cyc(0, 0, 0);
        check("t3_flap_en", int'(bus.flap_en), 1);
        check("t3_fall_suppressed", int'(bus.fall_en), 0);
        n_flap += int'(bus.flap_en);
        for (int k = 5; k <= 8; k++) begin
            cyc(0, 0, 0);
            n_flap += int'(bus.flap_en);
        end
        check("t3_next_fall", int'(bus.fall_en), 1);
        check("t3_flap_total", n_flap, 1);

        // 4: collision beats start, then OVER -> IDLE -> PLAY restarts timing
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0);
        cyc(1, 0, 1);
        check("t4_over", int'(bus.state), 3);
        hold_pulses = int'(bus.scroll_en) + int'(bus.fall_en) + int'(bus.spawn_en) + int'(bus.flap_en);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 1, 1);
            hold_pulses += int'(bus.scroll_en) + int'(bus.fall_en) + int'(bus.spawn_en) + int'(bus.flap_en);
        end
        check("t4_over_pulses", hold_pulses, 0);
        cyc(1, 0, 0);
        check("t4_idle", int'(bus.state), 0);
        cyc(1, 0, 0);
        check("t4_play", int'(bus.state), 1);
        first_scroll = -1;
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0);
            if (bus.scroll_en && first_scroll < 0) first_scroll = k;
        end
        check("t4_first_scroll", first_scroll, 8);

        // 5: 200 spawns, gap range and stability
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0);
        n_spawn = 0; range_bad = 0; stable_bad = 0; last_gap = bus.gap_top;
        for (int k = 0; k < 6000 && n_spawn < 200; k++) begin
            cyc(0, ($urandom_range(0, 6) == 0), 0);
            if (bus.spawn_en) begin
                n_spawn++;
                if (bus.gap_top < 4'd1 || bus.gap_top > 4'd12) range_bad++;
                last_gap = bus.gap_top;
            end else if (bus.gap_top != last_gap) begin
                stable_bad++;
            end
        end
        check("t5_spawn_count", n_spawn, 200);
        check("t5_gap_range", range_bad, 0);
        check("t5_gap_stable", stable_bad, 0);

        // 6: reset one cycle before a scheduled scroll_en
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0);
        for (int k = 1; k <= 7; k++) cyc(0, 0, 0);
        cyc(0, 0, 0, 1);
        check("t6_no_scroll", int'(bus.scroll_en), 0);
        check("t6_state", int'(bus.state), 0);
        check("t6_pause", int'(bus.pause), 1);
        check("t6_gap", int'(bus.gap_top), 0);
        check("t6_enables", int'({bus.spawn_en, bus.fall_en, bus.flap_en}), 0);
        cyc(1, 0, 0);
        first_spawn = -1;
        for (int k = 1; k <= 24; k++) begin
            cyc(0, 0, 0);
            if (bus.spawn_en && first_spawn < 0) begin
                first_spawn = k;
                check("t6_reseeded_gap", int'(bus.gap_top), 10);
            end
        end
        check("t6_first_spawn", first_spawn, 24);

        // Randomized traffic against the model
        cyc(0, 0, 0, 1);
        for (int k = 0; k < 4000; k++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 79) == 0), ($urandom_range(0, 1499) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
Game-level sequencer for the Flappy Birds datapath. It owns the game state machine and derives every slow timing enable from a single base prescaler:
- barrier scroll enable
- barrier spawn enable, with a pseudo-random gap row
- bird fall enable and bird flap enable

It arbitrates fall versus flap for the shared bird-position register. It drives pause to all tick consumers, replacing free-running per-block dividers.

Parameters:
BASE_DIV, 8192, clk cycles per base tick (prescaler modulus, >=2)
SCROLL_DIV, 4, base ticks per scroll_en pulse
SPAWN_DIV, 4, scroll steps per spawn_en pulse
FALL_DIV, 2, base ticks per fall opportunity
ROWS, 16, playfield rows
GAP, 4, barrier gap height in rows

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; clock clk
start  in  1  single-cycle pulse (debounced key): start / pause toggle / acknowledge game over
flap  in  1  single-cycle pulse, player flap request
collision  in  1  level, bird overlaps barrier or boundary
state  out  2  00 IDLE, 01 PLAY, 10 PAUSED, 11 OVER
pause  out  1  high whenever state != PLAY
scroll_en  out  1  one-cycle pulse: shift barriers one column
spawn_en  out  1  one-cycle pulse: insert new barrier column
gap_top  out  $clog2(ROWS)  top row of new gap, valid and held from spawn_en
fall_en  out  1  one-cycle pulse: bird moves down one row
flap_en  out  1  one-cycle pulse: bird moves up one row

Behaviour:
- Reset values: state=IDLE; pause=1; all enables 0; gap_top=0; prescaler and all divider counters 0; LFSR=4'b1001. Reset mid-game returns to exactly this state.
- FSM transitions, evaluated each cycle:
  - IDLE -start-> PLAY (clears prescaler and all dividers)
  - PLAY -collision-> OVER
  - PLAY -start-> PAUSED
  - PAUSED -start-> PLAY (counters resume, not cleared)
  - OVER -start-> IDLE
- Simultaneous collision and start in PLAY: collision wins and the next state is OVER.
- Counters in IDLE, PAUSED and OVER: frozen. No enable pulses in those states.
- Prescaler: counts 0..BASE_DIV-1 in PLAY. base_tick = (prescaler==BASE_DIV-1) in PLAY; prescaler wraps to 0 on that cycle.
- Scroll: scroll counter advances on base_tick, wraps at SCROLL_DIV-1. On wrap, scroll_en is registered high for the next cycle.
- Spawn: spawn counter advances on each scroll wrap, wraps at SPAWN_DIV-1. spawn_en pulses in the same cycle as the coincident scroll_en.
- Fall: fall counter advances on base_tick, wraps at FALL_DIV-1. A wrap is a fall opportunity.
- Flap arbitration:
  - A flap pulse in PLAY sets flap_pending. Multiple flaps before the next base_tick collapse into one.
  - On base_tick with flap_pending: flap_en pulses next cycle, flap_pending clears, and any coincident fall opportunity is suppressed (no fall_en).
  - Otherwise a fall opportunity produces fall_en.
  - flap_en and fall_en are never high together.
  - flap_pending clears on leaving PLAY.
- Output latency: all enables are registered, one cycle after the causing base_tick.
- Worked example (BASE_DIV=4, SCROLL_DIV=2, FALL_DIV=1): first scroll_en appears 8 cycles after state first reads PLAY, then repeats every 8 cycles.
- LFSR: 4-bit, taps x^4+x^3+1. Advances every cycle in all states, including frozen ones, so start timing adds entropy. It never reaches 0.
- gap_top: loaded when spawn_en is issued, from L = LFSR value at the base_tick.
  - If L > ROWS-GAP: gap_top = L-GAP.
  - Else: gap_top = L.
  - Result is always in 1..ROWS-GAP. It holds until the next spawn.
- Widths: each counter is $clog2 of its modulus, minimum 1 bit. Compares are against modulus-1; no wrap-around overflow is permitted.

Optional Feature:
SPEEDUP_EN
- Defined: a spawn counter saturating at 15 counts spawn_en pulses. Once it reaches 8, the effective scroll modulus becomes max(1, SCROLL_DIV/2) for the rest of the game. The spawn counter clears on IDLE->PLAY.
- Undefined: the scroll modulus is constant SCROLL_DIV and no spawn counter exists.

Decomposition:
- Package flappy_pkg holds:
  - game_state_t enum (IDLE, PLAY, PAUSED, OVER, 2-bit encodings as above)
  - LFSR_SEED constant 4'b1001
  - default ROWS/GAP constants
- Sub-module tick_divider (params MOD; ports clk, reset, clear, adv, wrap) is instantiated for scroll, spawn and fall.
- FSM, LFSR and flap arbitration stay in the top module.

Test Plan:
All scenarios use BASE_DIV=4, SCROLL_DIV=2, SPAWN_DIV=3, FALL_DIV=1, ROWS=16, GAP=4.
1. Reset, then start pulse -> state=01, pause=0. fall_en every 4 cycles; scroll_en every 8 cycles, first at cycle 8. spawn_en every 24 cycles, coincident with every third scroll_en.
2. In PLAY, start at cycle 10, hold 20 cycles, then start -> state=10 with no enables during the hold. On resume, pulse phase continues from the frozen counts; no pulse is lost or duplicated.
3. Three flap pulses within one base period -> exactly one flap_en at the next base tick, with fall_en absent that tick. The following tick produces fall_en.
4. collision and start high in the same PLAY cycle -> state=11, all enables 0. Then start -> IDLE. Then start -> PLAY with the first scroll_en again at cycle 8.
5. Run 200 spawns -> every gap_top in 1..12. gap_top is stable between spawns. It matches the reference LFSR model seeded with 4'b1001.
6. reset asserted mid-PLAY one cycle before a scheduled scroll_en -> no scroll_en emitted. All outputs return to reset values and the LFSR reseeds.
